// File: rtl/mips_bus_pkg.sv
// rtl/mips_bus_pkg.sv - shared types and constants for the mips_cpu_bus memory responder
//
// Purpose: reset vector, byte-lane masks, wait FSM state type and the
// LFSR seed/taps plus step function used for randomised wait states.
// Ports: none (package).
package mips_bus_pkg;

   localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

   typedef logic [3:0] byteen_t;

   localparam byteen_t BE_NONE    = 4'b0000;
   localparam byteen_t BE_WORD    = 4'b1111;
   localparam byteen_t BE_HALF_LO = 4'b0011;
   localparam byteen_t BE_HALF_HI = 4'b1100;
   localparam byteen_t BE_BYTE0   = 4'b0001;
   localparam byteen_t BE_BYTE1   = 4'b0010;
   localparam byteen_t BE_BYTE2   = 4'b0100;
   localparam byteen_t BE_BYTE3   = 4'b1000;

   typedef enum logic {
      IDLE  = 1'b0,
      STALL = 1'b1
   } mem_state_t;

   // Galois form of x^16 + x^14 + x^13 + x^11 + 1 (maximal length)
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/mips_bus_mem_responder_if.sv
// rtl/mips_bus_mem_responder_if.sv - Avalon-style CPU bus bundle for the memory responder
//
// Purpose: groups the CPU initiator signals.
// Signals: address, read, write, writedata, byteenable (initiator -> responder);
//          waitrequest, readdata, err (responder -> initiator).
// Modports: master (CPU side), slave (memory side).
interface mips_bus_mem_responder_if;
   import mips_bus_pkg::*;

   logic [31:0] address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   byteen_t     byteenable;
   logic        waitrequest;
   logic [31:0] readdata;
   logic        err;

   modport master (
      output address, read, write, writedata, byteenable,
      input  waitrequest, readdata, err
   );

   modport slave (
      input  address, read, write, writedata, byteenable,
      output waitrequest, readdata, err
   );

endinterface

// File: rtl/mips_bus_wait_gen.sv
// rtl/mips_bus_wait_gen.sv - wait-state counter and accept generation for the memory responder
//
// Purpose: stalls each request for a target number of cycles, then accepts it.
// Option: MIPS_MEM_RANDOM_WAIT_EN selects a per-transfer target from an LFSR
//         (modulo WAIT_CYCLES+1); otherwise the target is fixed at WAIT_CYCLES.
// Ports:
//   clk          in   clock
//   reset        in   synchronous, active-low
//   req          in   read | write from the CPU
//   waitrequest  out  high while the request is not accepted (forced high in reset)
//   accept       out  request accepted this cycle
module mips_bus_wait_gen
   import mips_bus_pkg::*;
#(
   parameter int WAIT_CYCLES = 0
) (
   input  logic clk,
   input  logic reset,
   input  logic req,
   output logic waitrequest,
   output logic accept
);

   mem_state_t state, state_n;
   logic [3:0] cnt, cnt_n;
   logic [3:0] target;

`ifdef MIPS_MEM_RANDOM_WAIT_EN
   logic [15:0] lfsr;

   // Advanced only on acceptance so the target stays stable for a whole transfer
   always_ff @(posedge clk) begin
      if (!reset) begin
         lfsr <= LFSR_SEED;
      end else if (accept) begin
         lfsr <= lfsr_step(lfsr);
      end
   end

   assign target = 4'(lfsr % 16'(WAIT_CYCLES + 1));
`else
   assign target = 4'(WAIT_CYCLES);
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      waitrequest = 1'b1;
      accept      = 1'b0;
      if (reset) begin
         waitrequest = req && (cnt != target);
         accept      = req && (cnt == target);
         case (state)
            IDLE: begin
               if (req && !accept) begin
                  state_n = STALL;
                  cnt_n   = cnt + 4'd1;
               end
            end
            STALL: begin
               // A withdrawn request also lands here and clears the count
               if (!req || accept) begin
                  state_n = IDLE;
                  cnt_n   = 4'd0;
               end else begin
                  cnt_n = cnt + 4'd1;
               end
            end
            default: begin
               state_n = IDLE;
               cnt_n   = 4'd0;
            end
         endcase
      end
   end

endmodule

// File: rtl/mips_bus_mem_responder.sv
// rtl/mips_bus_mem_responder.sv - word-array memory responder for the mips_cpu_bus initiator
//
// Purpose: maps CPU byte addresses (word 0 at BASE_ADDR) onto a word array,
// applies byteenable-masked writes, returns read data, flags bad transfers,
// and inserts wait states through mips_bus_wait_gen.
// Option: MIPS_MEM_RANDOM_WAIT_EN (in mips_bus_wait_gen) randomises stalls.
// Ports:
//   clk        in   clock
//   reset      in   synchronous, active-low (array contents survive reset)
//   bus        slave modport of mips_bus_mem_responder_if
//   init_en    in   preload strobe, honoured in and out of reset
//   init_addr  in   preload word index (>= DEPTH_WORDS ignored)
//   init_data  in   preload word
module mips_bus_mem_responder
   import mips_bus_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = RESET_VECTOR,
   parameter int          DEPTH_WORDS = 64,
   parameter int          WAIT_CYCLES = 0
) (
   input  logic                           clk,
   input  logic                           reset,
   mips_bus_mem_responder_if.slave        bus,
   input  logic                           init_en,
   input  logic [11:0]                    init_addr,
   input  logic [31:0]                    init_data
);

   localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [31:0] DEPTH_U = 32'(DEPTH_WORDS);

   logic [31:0]   mem [DEPTH_WORDS];
   logic          req;
   logic          accept;
   logic          waitrequest;
   logic [29:0]   word_off;
   logic          in_range;
   logic          init_hit;
   logic [AW-1:0] idx;
   logic          do_write;
   logic          do_read;
   logic          bad;

   assign req             = bus.read | bus.write;
   assign bus.waitrequest = waitrequest;

   mips_bus_wait_gen #(
      .WAIT_CYCLES (WAIT_CYCLES)
   ) u_wait_gen (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .waitrequest (waitrequest),
      .accept      (accept)
   );

   // Word offset from the base; the low address bits never select a lane
   assign word_off = bus.address[31:2] - BASE_ADDR[31:2];
   assign in_range = (bus.address >= BASE_ADDR) && ({2'b00, word_off} < DEPTH_U);
   assign idx      = word_off[AW-1:0];
   assign init_hit = init_en && ({20'd0, init_addr} < DEPTH_U);

   always_comb begin
      do_write = 1'b0;
      do_read  = 1'b0;
      bad      = 1'b0;
      if (accept) begin
         if (bus.read && bus.write) begin
            bad = 1'b1;
         end else if (bus.write) begin
            if (in_range && (bus.byteenable != BE_NONE)) begin
               do_write = 1'b1;
            end else begin
               bad = 1'b1;
            end
         end else begin
            do_read = 1'b1;
            // Address 0 is the CPU halt fetch: returns zero without an error
            bad = !in_range && (bus.address != 32'h0);
         end
      end
   end

   // Preload is applied last so it overrides a same-cycle bus write to that word
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (do_write && bus.byteenable[i]) begin
            mem[idx][8*i +: 8] <= bus.writedata[8*i +: 8];
         end
      end
      if (init_hit) begin
         mem[init_addr[AW-1:0]] <= init_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         bus.readdata <= 32'h0;
         bus.err      <= 1'b0;
      end else begin
         bus.err <= bad;
         if (do_read) begin
            bus.readdata <= in_range ? mem[idx] : 32'h0;
         end
      end
   end

endmodule
